// File: rtl/ball_physics.sv
// Per-frame ball motion engine. The ball state is fixed point with 16 subpixels per pixel.
// Each frame_tick runs a fixed pipeline (INTEG, WALL, PLAYER, COMMIT). Position and velocity
// are published on the same edge, so software never reads a half-updated frame.
module ball_physics #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int BALL_R     = 4,
    parameter int PLAYER_W   = 16,
    parameter int PLAYER_H   = 32,
    parameter int GRAVITY    = 2,
    parameter int DAMP_SHIFT = 2,
    parameter int REST_V     = 4,
    parameter int VMAX       = 1023,
    parameter int X0         = 5120,
    parameter int Y0         = 1920
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        launch,
    input  logic        serve,
    input  logic [31:0] aim,
    input  logic [31:0] p1_pos,
    input  logic [31:0] p2_pos,
    output logic [31:0] b1_pos,
    output logic [31:0] b1_vel,
    output logic        busy,
    output logic        hit_p1,
    output logic        hit_p2
);

    localparam logic [2:0] HELD   = 3'd0;
    localparam logic [2:0] READY  = 3'd1;
    localparam logic [2:0] INTEG  = 3'd2;
    localparam logic [2:0] WALL   = 3'd3;
    localparam logic [2:0] PLAYER = 3'd4;
    localparam logic [2:0] COMMIT = 3'd5;

    // Wall limits and hit windows, all in subpixels
    localparam logic signed [17:0] MIN_X  = 18'(BALL_R * 16);
    localparam logic signed [17:0] MAX_X  = 18'((SCREEN_W - BALL_R) * 16);
    localparam logic signed [17:0] MIN_Y  = 18'(BALL_R * 16);
    localparam logic signed [17:0] MAX_Y  = 18'((SCREEN_H - BALL_R) * 16);
    localparam logic        [17:0] HIT_X  = 18'((PLAYER_W / 2 + BALL_R) * 16);
    localparam logic        [17:0] HIT_Y  = 18'((PLAYER_H / 2 + BALL_R) * 16);
    localparam logic signed [17:0] VMAX_S = 18'(VMAX);
    localparam logic signed [17:0] GRAV_S = 18'(GRAVITY);
    localparam logic        [17:0] REST_S = 18'(REST_V);
    localparam logic        [15:0] X0_P   = 16'(X0);
    localparam logic        [15:0] Y0_P   = 16'(Y0);

    function automatic logic signed [17:0] sat18(input logic signed [17:0] v);
        if (v > VMAX_S) begin
            return VMAX_S;
        end
        if (v < -VMAX_S) begin
            return -VMAX_S;
        end
        return v;
    endfunction

    function automatic logic [15:0] sat_aim(input logic [15:0] v);
        return 16'(sat18({{2{v[15]}}, v}));
    endfunction

    function automatic logic [17:0] abs18(input logic signed [17:0] v);
        return v[17] ? 18'(-v) : 18'(v);
    endfunction

    // Bounce loses a fixed fraction of speed
    function automatic logic [17:0] damp(input logic [17:0] m);
        return m - (m >> DAMP_SHIFT);
    endfunction

    logic [2:0]         state_q, state_d;
    logic [15:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [15:0]        vel_x_q, vel_x_d, vel_y_q, vel_y_d;
    logic signed [17:0] x_w_q, x_w_d, y_w_q, y_w_d;
    logic signed [17:0] vx_w_q, vx_w_d, vy_w_q, vy_w_d;
    logic               hit1_w_q, hit1_w_d, hit2_w_q, hit2_w_d;
    logic               busy_q, busy_d;
    logic               hit_p1_q, hit_p1_d, hit_p2_q, hit_p2_d;

    // Integration datapath
    logic signed [17:0] vx_cur, vy_cur, vy_int, x_int, y_int;
    assign vx_cur = {{2{vel_x_q[15]}}, vel_x_q};
    assign vy_cur = {{2{vel_y_q[15]}}, vel_y_q};
    assign vy_int = sat18(vy_cur + GRAV_S);
    assign x_int  = $signed({2'b00, pos_x_q}) + vx_cur;
    assign y_int  = $signed({2'b00, pos_y_q}) + vy_int;

    // Wall datapath
    logic [17:0] vx_damp, vy_damp;
    assign vx_damp = damp(abs18(vx_w_q));
    assign vy_damp = damp(abs18(vy_w_q));

    // Player datapath, on post-wall values
    logic signed [17:0] p1_dx, p1_dy, p2_dx, p2_dy;
    logic               moving_down, hit1, hit2;
    assign p1_dx = x_w_q - $signed({2'b00, p1_pos[15:0]});
    assign p1_dy = y_w_q - $signed({2'b00, p1_pos[31:16]});
    assign p2_dx = x_w_q - $signed({2'b00, p2_pos[15:0]});
    assign p2_dy = y_w_q - $signed({2'b00, p2_pos[31:16]});
    assign moving_down = !vy_w_q[17] && (vy_w_q != '0);
    assign hit1 = (abs18(p1_dx) < HIT_X) && (abs18(p1_dy) < HIT_Y) && moving_down;
    assign hit2 = (abs18(p2_dx) < HIT_X) && (abs18(p2_dy) < HIT_Y) && moving_down;

    // Next-state logic for the frame pipeline and the published state
    always_comb begin
        state_d  = state_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        vel_x_d  = vel_x_q;
        vel_y_d  = vel_y_q;
        x_w_d    = x_w_q;
        y_w_d    = y_w_q;
        vx_w_d   = vx_w_q;
        vy_w_d   = vy_w_q;
        hit1_w_d = hit1_w_q;
        hit2_w_d = hit2_w_q;
        busy_d   = busy_q;
        hit_p1_d = 1'b0;
        hit_p2_d = 1'b0;

        case (state_q)
            HELD: begin
                // frame_tick is dropped here, even when it coincides with launch
                if (launch) begin
                    vel_x_d = sat_aim(aim[15:0]);
                    vel_y_d = sat_aim(aim[31:16]);
                    state_d = READY;
                end
            end
            READY: begin
                if (serve) begin
                    pos_x_d = X0_P;
                    pos_y_d = Y0_P;
                    vel_x_d = '0;
                    vel_y_d = '0;
                    state_d = HELD;
                end else if (frame_tick) begin
                    busy_d  = 1'b1;
                    state_d = INTEG;
                end
            end
            INTEG: begin
                vx_w_d   = vx_cur;
                vy_w_d   = vy_int;
                x_w_d    = x_int;
                y_w_d    = y_int;
                hit1_w_d = 1'b0;
                hit2_w_d = 1'b0;
                state_d  = WALL;
            end
            WALL: begin
                if (x_w_q < MIN_X) begin
                    x_w_d  = MIN_X;
                    vx_w_d = $signed(vx_damp);
                end else if (x_w_q > MAX_X) begin
                    x_w_d  = MAX_X;
                    vx_w_d = -$signed(vx_damp);
                end
                if (y_w_q < MIN_Y) begin
                    y_w_d  = MIN_Y;
                    vy_w_d = $signed(vy_damp);
                end else if (y_w_q > MAX_Y) begin
                    y_w_d  = MAX_Y;
                    // Slow floor bounces come to rest instead of jittering
                    vy_w_d = (vy_damp < REST_S) ? '0 : -$signed(vy_damp);
                end
                state_d = PLAYER;
            end
            PLAYER: begin
                // Player 1 wins a simultaneous overlap
                if (hit1 || hit2) begin
                    vy_w_d = -$signed(vy_damp);
                end
                hit1_w_d = hit1;
                hit2_w_d = hit2 && !hit1;
                state_d  = COMMIT;
            end
            COMMIT: begin
                pos_x_d  = x_w_q[15:0];
                pos_y_d  = y_w_q[15:0];
                vel_x_d  = vx_w_q[15:0];
                vel_y_d  = vy_w_q[15:0];
                hit_p1_d = hit1_w_q;
                hit_p2_d = hit2_w_q;
                busy_d   = 1'b0;
                state_d  = READY;
            end
            default: begin
                state_d = HELD;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any in-flight frame
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= HELD;
            pos_x_q  <= X0_P;
            pos_y_q  <= Y0_P;
            vel_x_q  <= '0;
            vel_y_q  <= '0;
            x_w_q    <= '0;
            y_w_q    <= '0;
            vx_w_q   <= '0;
            vy_w_q   <= '0;
            hit1_w_q <= 1'b0;
            hit2_w_q <= 1'b0;
            busy_q   <= 1'b0;
            hit_p1_q <= 1'b0;
            hit_p2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            vel_x_q  <= vel_x_d;
            vel_y_q  <= vel_y_d;
            x_w_q    <= x_w_d;
            y_w_q    <= y_w_d;
            vx_w_q   <= vx_w_d;
            vy_w_q   <= vy_w_d;
            hit1_w_q <= hit1_w_d;
            hit2_w_q <= hit2_w_d;
            busy_q   <= busy_d;
            hit_p1_q <= hit_p1_d;
            hit_p2_q <= hit_p2_d;
        end
    end

    assign b1_pos = {pos_y_q, pos_x_q};
    assign b1_vel = {vel_y_q, vel_x_q};
    assign busy   = busy_q;
    assign hit_p1 = hit_p1_q;
    assign hit_p2 = hit_p2_q;

endmodule

// File: tb/tb_ball_physics.sv
// Directed bench for ball_physics: hand-computed frames covering reset, launch, walls,
// ceiling, floor, player hits and ignored or aborted inputs.
module tb_ball_physics;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        launch = 1'b0;
    logic        serve = 1'b0;
    logic [31:0] aim = '0;
    logic [31:0] p1_pos = '0;
    logic [31:0] p2_pos = '0;
    logic [31:0] b1_pos, b1_vel;
    logic        busy, hit_p1, hit_p2;

    int n_err = 0;
    int n_chk = 0;

    ball_physics dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .launch     (launch),
        .serve      (serve),
        .aim        (aim),
        .p1_pos     (p1_pos),
        .p2_pos     (p2_pos),
        .b1_pos     (b1_pos),
        .b1_vel     (b1_vel),
        .busy       (busy),
        .hit_p1     (hit_p1),
        .hit_p2     (hit_p2)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_launch(input logic [31:0] a);
        aim = a;
        launch = 1'b1;
        @(negedge Clk);
        launch = 1'b0;
    endtask

    task automatic do_serve();
        serve = 1'b1;
        @(negedge Clk);
        serve = 1'b0;
    endtask

    // One frame; busy must be high for exactly four cycles and outputs hold until commit
    task automatic frame(input logic extra_tick, input logic serve_mid);
        logic [31:0] old_pos;
        old_pos = b1_pos;
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = extra_tick;
        serve = serve_mid;
        for (int i = 0; i < 4; i++) begin
            chk("busy_in_frame", 32'(busy), 32'd1);
            chk("pos_hold_in_frame", b1_pos, old_pos);
            @(negedge Clk);
            frame_tick = 1'b0;
            serve = 1'b0;
        end
        chk("busy_after_frame", 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        // Reset state
        chk("rst_pos", b1_pos, 32'h0780_1400);
        chk("rst_vel", b1_vel, 32'h0000_0000);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hits", {30'd0, hit_p2, hit_p1}, 32'd0);

        // frame_tick in HELD is ignored
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        chk("held_tick_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge Clk);
        chk("held_tick_pos", b1_pos, 32'h0780_1400);
        chk("held_tick_vel", b1_vel, 32'h0000_0000);

        // launch with tick in the same cycle: launch wins, aim saturates
        frame_tick = 1'b1;
        do_launch(32'h7FFF_8000);
        frame_tick = 1'b0;
        chk("sat_vel", b1_vel, 32'h03FF_FC01);
        chk("sat_busy", 32'(busy), 32'd0);
        do_serve();
        chk("serve_pos", b1_pos, 32'h0780_1400);
        chk("serve_vel", b1_vel, 32'h0000_0000);

        // Basic integration; launch in READY is ignored
        do_launch(32'hFFE0_0030);
        chk("launch_vel", b1_vel, 32'hFFE0_0030);
        chk("launch_pos", b1_pos, 32'h0780_1400);
        do_launch(32'h1234_5678);
        chk("ready_launch_ignored", b1_vel, 32'hFFE0_0030);
        frame(1'b0, 1'b0);
        chk("integ_pos", b1_pos, 32'h0762_1430);
        chk("integ_vel", b1_vel, 32'hFFE2_0030);
        chk("integ_hits", {30'd0, hit_p2, hit_p1}, 32'd0);

        // Right wall after five free frames; serve during the sixth is ignored
        do_serve();
        do_launch(32'hFFF6_03F0);
        for (int f = 0; f < 5; f++) frame(1'b0, 1'b0);
        chk("wall_pre_pos", b1_pos, 32'h076C_27B0);
        chk("wall_pre_vel", b1_vel, 32'h0000_03F0);
        frame(1'b0, 1'b1);
        chk("wall_pos", b1_pos, 32'h076E_27C0);
        chk("wall_vel", b1_vel, 32'h0002_FD0C);
        chk("wall_hits", {30'd0, hit_p2, hit_p1}, 32'd0);

        // Ceiling bounce
        do_serve();
        do_launch(32'h8000_0000);
        chk("ceil_launch_vel", b1_vel, 32'hFC01_0000);
        frame(1'b0, 1'b0);
        chk("ceil_pre_pos", b1_pos, 32'h0383_1400);
        chk("ceil_pre_vel", b1_vel, 32'hFC03_0000);
        frame(1'b0, 1'b0);
        chk("ceil_pos", b1_pos, 32'h0040_1400);
        chk("ceil_vel", b1_vel, 32'h02FD_0000);

        // Floor bounce
        do_serve();
        do_launch(32'h03E8_0000);
        for (int f = 0; f < 6; f++) frame(1'b0, 1'b0);
        chk("floor_pos", b1_pos, 32'h1DC0_1400);
        chk("floor_vel", b1_vel, 32'hFD09_0000);

        // Player hit, both overlapping: p1 reported; second tick while busy ignored
        do_serve();
        p1_pos = 32'h08C0_1400;
        p2_pos = 32'h08C0_1400;
        do_launch(32'h0012_0000);
        frame(1'b1, 1'b0);
        chk("hit_pos", b1_pos, 32'h0794_1400);
        chk("hit_vel", b1_vel, 32'hFFF1_0000);
        chk("hit_p1_pulse", 32'(hit_p1), 32'd1);
        chk("hit_p2_quiet", 32'(hit_p2), 32'd0);
        @(negedge Clk);
        chk("hit_p1_one_cycle", 32'(hit_p1), 32'd0);
        repeat (6) @(negedge Clk);
        chk("extra_tick_busy", 32'(busy), 32'd0);
        chk("extra_tick_pos", b1_pos, 32'h0794_1400);

        // Player 2 alone
        do_serve();
        p1_pos = 32'h0000_0000;
        do_launch(32'h0012_0000);
        frame(1'b0, 1'b0);
        chk("hit2_vel", b1_vel, 32'hFFF1_0000);
        chk("hit2_flags", {30'd0, hit_p2, hit_p1}, 32'd2);

        // Reset in INTEG aborts the frame
        do_serve();
        p1_pos = 32'h08C0_1400;
        do_launch(32'h0012_0000);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("abort_pos", b1_pos, 32'h0780_1400);
        chk("abort_vel", b1_vel, 32'h0000_0000);
        chk("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("abort_no_hit", {30'd0, hit_p2, hit_p1}, 32'd0);
            @(negedge Clk);
        end
        chk("abort_pos_hold", b1_pos, 32'h0780_1400);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
